// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A command sequencer.
// Imported by the synchronizer and the sequencer top.
package pic_pkg;

    typedef enum logic [2:0] {
        S_ICW1,
        S_ICW2,
        S_ICW3,
        S_ICW4,
        S_READY
    } state_e;

    localparam logic [1:0] RDSEL_NONE = 2'b00;
    localparam logic [1:0] RDSEL_IRR  = 2'b01;
    localparam logic [1:0] RDSEL_ISR  = 2'b10;
    localparam logic [1:0] RDSEL_IMR  = 2'b11;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D4    = 4;
    localparam int OCW3_D3   = 3;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    // Sync chain reset image {cs_n, wr_n, rd_n, a0, din}; wr_n resets low
    // so a strobe held across reset is never mistaken for a fresh write.
    localparam logic [11:0] SYNC_RST = 12'hA00;

endpackage

// File: rtl/pic_strobe_sync.sv
// Synchronizer chain for the CPU bus pins, wr_n rising-edge detect and
// write capture; the same chain also delivers the synchronized rd path.
module pic_strobe_sync
    import pic_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       cs_n_s,
    output logic       wr_n_s,
    output logic       rd_n_s,
    output logic       a0_s,
    output logic       wr_evt,
    output logic       a0_lat,
    output logic [7:0] din_lat
);

    logic [11:0] sync_q [STAGES];
    logic [11:0] tap;
    logic [7:0]  din_s;
    logic        wr_prev_q;
    logic        armed_q;
    logic        cs_lat_q;
    logic        a0_lat_q;
    logic [7:0]  din_lat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {cs_n, wr_n, rd_n, a0, din};
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign tap    = sync_q[STAGES-1];
    assign cs_n_s = tap[11];
    assign wr_n_s = tap[10];
    assign rd_n_s = tap[9];
    assign a0_s   = tap[8];
    assign din_s  = tap[7:0];

    // wr_n must be seen high after reset before any capture is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            cs_lat_q  <= 1'b0;
            a0_lat_q  <= 1'b0;
            din_lat_q <= 8'h00;
        end else begin
            wr_prev_q <= wr_n_s;
            if (wr_n_s) armed_q <= 1'b1;
            if (wr_n_s && !wr_prev_q) begin
                cs_lat_q <= 1'b0;
            end else if (armed_q && !wr_n_s && !cs_n_s) begin
                cs_lat_q  <= 1'b1;
                a0_lat_q  <= a0_s;
                din_lat_q <= din_s;
            end
        end
    end

    assign wr_evt  = wr_n_s & ~wr_prev_q & cs_lat_q;
    assign a0_lat  = a0_lat_q;
    assign din_lat = din_lat_q;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259A command sequencer: ICW1..ICW4 init walk, OCW decode in READY,
// change pulses for the control logic and read-source select.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] ocw1,
    output logic [7:0] ocw2,
    output logic [7:0] ocw3,
    output logic       init_done,
    output logic       ocw2_pulse,
    output logic       ocw3_pulse,
    output logic       poll_pulse,
    output logic       smm,
    output logic [1:0] rd_sel,
    output logic       seq_err
);

    logic       cs_s, wr_s, rd_s, a0_s, wr_evt, a0_l;
    logic [7:0] din_l;

    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .a0      (a0),
        .din     (din),
        .cs_n_s  (cs_s),
        .wr_n_s  (wr_s),
        .rd_n_s  (rd_s),
        .a0_s    (a0_s),
        .wr_evt  (wr_evt),
        .a0_lat  (a0_l),
        .din_lat (din_l)
    );

    state_e     state_q, state_d;
    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0] ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
    logic       smm_q, smm_d, done_q, done_d;
    logic       p2_q, p2_d, p3_q, p3_d, poll_q, poll_d, err_q, err_d;
    logic [1:0] rdlat_q, rdlat_d, rdsel_q, rdsel_d;

    always_comb begin
        state_d = state_q;
        icw1_d  = icw1_q;
        icw2_d  = icw2_q;
        icw3_d  = icw3_q;
        icw4_d  = icw4_q;
        ocw1_d  = ocw1_q;
        ocw2_d  = ocw2_q;
        ocw3_d  = ocw3_q;
        smm_d   = smm_q;
        rdlat_d = rdlat_q;
        p2_d    = 1'b0;
        p3_d    = 1'b0;
        poll_d  = 1'b0;
        err_d   = 1'b0;
        if (wr_evt) begin
            if (!a0_l && din_l[CMD_D4]) begin
                icw1_d  = din_l;
                icw2_d  = 8'h00;
                icw3_d  = 8'h00;
                icw4_d  = 8'h00;
                ocw1_d  = 8'h00;
                smm_d   = 1'b0;
                rdlat_d = RDSEL_IRR;
                state_d = S_ICW2;
            end else begin
                unique case (state_q)
                    S_ICW1: err_d = 1'b1;
                    S_ICW2: begin
                        if (a0_l) begin
                            icw2_d = din_l;
                            if (!icw1_q[ICW1_SNGL])    state_d = S_ICW3;
                            else if (icw1_q[ICW1_IC4]) state_d = S_ICW4;
                            else                       state_d = S_READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_ICW3: begin
                        if (a0_l) begin
                            icw3_d  = din_l;
                            state_d = icw1_q[ICW1_IC4] ? S_ICW4 : S_READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_ICW4: begin
                        if (a0_l) begin
                            icw4_d  = din_l;
                            state_d = S_READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_READY: begin
                        if (a0_l) begin
                            ocw1_d = din_l;
                        end else if (!din_l[OCW3_D3]) begin
                            ocw2_d = din_l;
                            p2_d   = 1'b1;
                        end else begin
                            ocw3_d = din_l;
                            p3_d   = 1'b1;
                            poll_d = din_l[OCW3_P];
                            if (din_l[OCW3_ESMM]) smm_d = din_l[OCW3_SMM];
                            if (din_l[OCW3_RR])
                                rdlat_d = din_l[OCW3_RIS] ? RDSEL_ISR : RDSEL_IRR;
                        end
                    end
                    default: state_d = S_ICW1;
                endcase
            end
        end
        done_d  = (state_d == S_READY);
        // a concurrent write strobe always wins over a read
        rdsel_d = RDSEL_NONE;
        if (!cs_s && !rd_s && wr_s && done_q)
            rdsel_d = a0_s ? RDSEL_IMR : rdlat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ICW1;
            icw1_q  <= 8'h00;
            icw2_q  <= 8'h00;
            icw3_q  <= 8'h00;
            icw4_q  <= 8'h00;
            ocw1_q  <= 8'h00;
            ocw2_q  <= 8'h00;
            ocw3_q  <= 8'h00;
            smm_q   <= 1'b0;
            done_q  <= 1'b0;
            rdlat_q <= RDSEL_IRR;
            rdsel_q <= RDSEL_NONE;
            p2_q    <= 1'b0;
            p3_q    <= 1'b0;
            poll_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icw1_q  <= icw1_d;
            icw2_q  <= icw2_d;
            icw3_q  <= icw3_d;
            icw4_q  <= icw4_d;
            ocw1_q  <= ocw1_d;
            ocw2_q  <= ocw2_d;
            ocw3_q  <= ocw3_d;
            smm_q   <= smm_d;
            done_q  <= done_d;
            rdlat_q <= rdlat_d;
            rdsel_q <= rdsel_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
        end
    end

    assign icw1       = icw1_q;
    assign icw2       = icw2_q;
    assign icw3       = icw3_q;
    assign icw4       = icw4_q;
    assign ocw1       = ocw1_q;
    assign ocw2       = ocw2_q;
    assign ocw3       = ocw3_q;
    assign init_done  = done_q;
    assign smm        = smm_q;
    assign rd_sel     = rdsel_q;
    assign ocw2_pulse = p2_q;
    assign ocw3_pulse = p3_q;
    assign poll_pulse = poll_q;
    assign seq_err    = err_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Bench for pic_cmd_sequencer: vector table, corner sequences and
// random writes/reads against a queue-based model of the init walk.
module tb_pic_cmd_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, wr_n, rd_n, a0;
    logic [7:0] din;
    logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       init_done, ocw2_pulse, ocw3_pulse, poll_pulse, smm, seq_err;
    logic [1:0] rd_sel;

    pic_cmd_sequencer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .a0(a0), .din(din), .icw1(icw1), .icw2(icw2), .icw3(icw3),
        .icw4(icw4), .ocw1(ocw1), .ocw2(ocw2), .ocw3(ocw3),
        .init_done(init_done), .ocw2_pulse(ocw2_pulse),
        .ocw3_pulse(ocw3_pulse), .poll_pulse(poll_pulse), .smm(smm),
        .rd_sel(rd_sel), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 1..4 = icw1..icw4, 5..7 = ocw1..ocw3
    logic [7:0] m_reg [1:7];
    int         pend[$];
    bit         m_started, m_smm, m_isr;
    logic [3:0] m_pul;
    logic [3:0] s_pul;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [3:0] pul;
        logic       done;
        logic       smm;
        int         s1;
        logic [7:0] v1;
        int         s2;
        logic [7:0] v2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic a, logic [7:0] d, logic [3:0] p,
                                logic dn, logic sm, int s1, logic [7:0] v1,
                                int s2, logic [7:0] v2);
        vec_t v;
        v.a0 = a; v.d = d; v.pul = p; v.done = dn; v.smm = sm;
        v.s1 = s1; v.v1 = v1; v.s2 = s2; v.v2 = v2;
        return v;
    endfunction

    function automatic logic [7:0] dut_reg(int i);
        case (i)
            1: return icw1;
            2: return icw2;
            3: return icw3;
            4: return icw4;
            5: return ocw1;
            6: return ocw2;
            7: return ocw3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic string rname(int i);
        case (i)
            1: return "icw1";
            2: return "icw2";
            3: return "icw3";
            4: return "icw4";
            5: return "ocw1";
            6: return "ocw2";
            7: return "ocw3";
            default: return "none";
        endcase
    endfunction

    function automatic bit m_done();
        return m_started && (pend.size() == 0);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 1; i <= 7; i++) m_reg[i] = 8'h00;
        pend.delete();
        m_started = 0; m_smm = 0; m_isr = 0; m_pul = 4'b0000;
    endtask

    // pulse vector order: {seq_err, ocw2_pulse, ocw3_pulse, poll_pulse}
    task automatic m_apply(input logic a, input logic [7:0] d);
        m_pul = 4'b0000;
        if (!a && d[4]) begin
            m_reg[1] = d;
            for (int i = 2; i <= 5; i++) m_reg[i] = 8'h00;
            m_smm = 0; m_isr = 0; m_started = 1;
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
        end else if (!m_started) begin
            m_pul[3] = 1'b1;
        end else if (pend.size() > 0) begin
            if (a) m_reg[pend.pop_front()] = d;
            else   m_pul[3] = 1'b1;
        end else if (a) begin
            m_reg[5] = d;
        end else if (!d[3]) begin
            m_reg[6] = d;
            m_pul[2] = 1'b1;
        end else begin
            m_reg[7] = d;
            m_pul[1] = 1'b1;
            m_pul[0] = d[2];
            if (d[6]) m_smm = d[5];
            if (d[1]) m_isr = d[0];
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 1; i <= 7; i++)
            chk({tag, "_", rname(i)}, dut_reg(i), m_reg[i]);
        chk({tag, "_done"}, {7'b0, init_done}, {7'b0, m_done()});
        chk({tag, "_smm"}, {7'b0, smm}, {7'b0, m_smm});
    endtask

    task automatic do_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_n = 1'b1;
        repeat (S) @(negedge clk);
        chk("done_early", {7'b0, init_done}, {7'b0, m_done()});
        chk("pulse_early", {4'b0, seq_err, ocw2_pulse, ocw3_pulse, poll_pulse}, 8'h00);
        @(negedge clk);
        s_pul = {seq_err, ocw2_pulse, ocw3_pulse, poll_pulse};
        m_apply(a, d);
        chk("pulses", {4'b0, s_pul}, {4'b0, m_pul});
        cs_n = 1'b1;
        @(negedge clk);
        chk("pulse_width", {4'b0, seq_err, ocw2_pulse, ocw3_pulse, poll_pulse}, 8'h00);
    endtask

    task automatic do_read(input logic a, input logic [1:0] exp, input string nm);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        repeat (S + 2) @(negedge clk);
        chk(nm, {6'b0, rd_sel}, {6'b0, exp});
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        chk("rd_idle", {6'b0, rd_sel}, 8'h00);
    endtask

    function automatic logic [1:0] m_rdsel(logic a);
        if (!m_done()) return 2'b00;
        if (a) return 2'b11;
        return m_isr ? 2'b10 : 2'b01;
    endfunction

    initial begin
        tbl.push_back(mk(1, 8'h55, 4'b1000, 0, 0, 1, 8'h00, 5, 8'h00));
        tbl.push_back(mk(0, 8'h11, 4'b0000, 0, 0, 1, 8'h11, 2, 8'h00));
        tbl.push_back(mk(1, 8'h20, 4'b0000, 0, 0, 2, 8'h20, 3, 8'h00));
        tbl.push_back(mk(1, 8'h04, 4'b0000, 0, 0, 3, 8'h04, 4, 8'h00));
        tbl.push_back(mk(1, 8'h01, 4'b0000, 1, 0, 4, 8'h01, 1, 8'h11));
        tbl.push_back(mk(1, 8'hA5, 4'b0000, 1, 0, 5, 8'hA5, 4, 8'h01));
        tbl.push_back(mk(0, 8'h20, 4'b0100, 1, 0, 6, 8'h20, 7, 8'h00));
        tbl.push_back(mk(0, 8'h0B, 4'b0010, 1, 0, 7, 8'h0B, 6, 8'h20));
        tbl.push_back(mk(0, 8'h68, 4'b0010, 1, 1, 7, 8'h68, 5, 8'hA5));
        tbl.push_back(mk(0, 8'h0C, 4'b0011, 1, 1, 7, 8'h0C, 6, 8'h20));
        tbl.push_back(mk(0, 8'h48, 4'b0010, 1, 0, 7, 8'h48, 5, 8'hA5));
        tbl.push_back(mk(0, 8'h12, 4'b0000, 0, 0, 1, 8'h12, 5, 8'h00));
        tbl.push_back(mk(1, 8'h40, 4'b0000, 1, 0, 2, 8'h40, 4, 8'h00));
        tbl.push_back(mk(1, 8'hFF, 4'b0000, 1, 0, 5, 8'hFF, 3, 8'h00));
        tbl.push_back(mk(0, 8'h11, 4'b0000, 0, 0, 1, 8'h11, 5, 8'h00));
        tbl.push_back(mk(1, 8'h20, 4'b0000, 0, 0, 2, 8'h20, 3, 8'h00));
        tbl.push_back(mk(0, 8'h00, 4'b1000, 0, 0, 2, 8'h20, 3, 8'h00));
        tbl.push_back(mk(1, 8'h07, 4'b0000, 0, 0, 3, 8'h07, 4, 8'h00));
        tbl.push_back(mk(0, 8'h13, 4'b0000, 0, 0, 1, 8'h13, 2, 8'h00));
        tbl.push_back(mk(1, 8'h20, 4'b0000, 0, 0, 2, 8'h20, 3, 8'h00));
        tbl.push_back(mk(0, 8'h08, 4'b1000, 0, 0, 4, 8'h00, 2, 8'h20));
        tbl.push_back(mk(1, 8'h03, 4'b0000, 1, 0, 4, 8'h03, 3, 8'h00));

        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        a0 = 1'b0; din = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);
        chk_all("rst");
        chk("rst_rdsel", {6'b0, rd_sel}, 8'h00);
        chk("rst_pulses", {4'b0, seq_err, ocw2_pulse, ocw3_pulse, poll_pulse}, 8'h00);
        rst_n = 1'b1;
        repeat (S + 2) @(negedge clk);

        foreach (tbl[k]) begin
            do_write(tbl[k].a0, tbl[k].d);
            chk($sformatf("tbl%0d_pul", k), {4'b0, s_pul}, {4'b0, tbl[k].pul});
            chk($sformatf("tbl%0d_done", k), {7'b0, init_done}, {7'b0, tbl[k].done});
            chk($sformatf("tbl%0d_smm", k), {7'b0, smm}, {7'b0, tbl[k].smm});
            chk($sformatf("tbl%0d_%s", k, rname(tbl[k].s1)), dut_reg(tbl[k].s1), tbl[k].v1);
            chk($sformatf("tbl%0d_%s", k, rname(tbl[k].s2)), dut_reg(tbl[k].s2), tbl[k].v2);
        end
        chk_all("tbl_end");

        do_read(0, 2'b01, "rd_irr");
        do_write(0, 8'h0B);
        do_read(0, 2'b10, "rd_isr");
        do_read(1, 2'b11, "rd_imr");

        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b1; din = 8'h3C; wr_n = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("rd_wr_force", {6'b0, rd_sel}, 8'h00);
        wr_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        m_apply(1'b1, 8'h3C);
        repeat (S + 2) @(negedge clk);
        chk("rd_wr_ocw1", ocw1, 8'h3C);

        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b0; din = 8'h13; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all("midrst");
        chk("midrst_rdsel", {6'b0, rd_sel}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        cs_n = 1'b1;
        chk_all("postrst");
        chk("postrst_err", {7'b0, seq_err}, 8'h00);
        do_read(0, 2'b00, "rd_before_init");

        for (int n = 0; n < 250; n++) begin
            logic       ra;
            logic [7:0] rd;
            ra = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            do_write(ra, rd);
            chk_all("rnd");
            if ($urandom_range(0, 3) == 0) begin
                ra = 1'($urandom_range(0, 1));
                do_read(ra, m_rdsel(ra), "rnd_rdsel");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
